// File: rtl/pc_rx_loader_pkg.sv
// Shared types and constants for the UART-to-RAM word loader.
// The baud divider is common with the RAM-to-PC dumper.
package pc_rx_loader_pkg;

   typedef enum logic {IDLE, ARMED} state_t;
   typedef logic [1:0] byte_idx_t;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h10003F10;
   localparam int          DEFAULT_NWORDS    = 8;
   localparam int          BAUD_DIV          = 12432;
   // Two byte times of silence inside a word is treated as a lost byte.
   localparam int          DEFAULT_TIMEOUT   = 2 * BAUD_DIV;

   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [3:0] idx);
      return base + {26'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/pc_rx_loader_if.sv
// Receive-byte stream and RAM write port seen by the loader.
interface pc_rx_loader_if;

   logic        rxvalid;
   logic [7:0]  rxdata;
   logic        gnt;
   logic        req_o;
   logic        we;
   logic [31:0] w_addr;
   logic [31:0] w_data;

   modport master (
      input  rxvalid, rxdata, gnt,
      output req_o, we, w_addr, w_data
   );

   modport slave (
      output rxvalid, rxdata, gnt,
      input  req_o, we, w_addr, w_data
   );

endinterface

// File: rtl/pc_rx_loader_rx_word_assembler.sv
// Packs received bytes into big-endian words and discards a partial
// word when the line stays idle too long between its bytes.
module pc_rx_loader_rx_word_assembler
   import pc_rx_loader_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        armed,
   input  logic        rxvalid,
   input  logic [7:0]  rxdata,
   output logic        word_valid,
   output logic [31:0] word,
   output logic        timeout
);

   localparam int GW = $clog2(TIMEOUT + 1);

   logic [23:0]   shift_reg;
   byte_idx_t     idx_reg;
   logic [GW-1:0] gap_reg;

   // Combinational so the RAM request can rise one cycle after the 4th byte.
   assign word_valid = armed && rxvalid && (idx_reg == 2'd3);
   assign word       = {shift_reg, rxdata};
   // A byte arriving on the expiry cycle takes precedence over the timeout.
   assign timeout    = armed && !rxvalid && (idx_reg != 2'd0) && (gap_reg == GW'(TIMEOUT));

   always_ff @(posedge clk) begin
      if (!rst || !armed) begin
         shift_reg <= '0;
         idx_reg   <= '0;
         gap_reg   <= '0;
      end else if (rxvalid) begin
         shift_reg <= {shift_reg[15:0], rxdata};
         idx_reg   <= idx_reg + 2'd1;
         gap_reg   <= '0;
      end else if (timeout) begin
         idx_reg   <= '0;
         gap_reg   <= '0;
      end else if (idx_reg != 2'd0) begin
         gap_reg   <= gap_reg + 1'b1;
      end
   end

endmodule

// File: rtl/pc_rx_loader.sv
// Loads NWORDS big-endian words received over the UART into data RAM
// starting at BASE_ADDR, one outstanding write at a time.
module pc_rx_loader
   import pc_rx_loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int          NWORDS    = DEFAULT_NWORDS,
   parameter int          TIMEOUT   = DEFAULT_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   pc_rx_loader_if.master    bus,
   output logic              busy,
   output logic              done,
   output logic              err_timeout,
   output logic              err_ovf,
   output logic [3:0]        wcount
);

   state_t      state_reg;
   logic        pending_reg;
   logic        req_reg;
   logic [31:0] addr_reg;
   logic [31:0] data_reg;
   logic [3:0]  acc_reg;
   logic [3:0]  wcount_reg;
   logic        busy_reg;
   logic        done_reg;
   logic        err_timeout_reg;
   logic        err_ovf_reg;

   logic        word_valid;
   logic [31:0] word;
   logic        timeout;
   logic        grant;
   logic        want;
   logic        accept;
   logic        overflow;
   logic        last;

   pc_rx_loader_rx_word_assembler #(
      .TIMEOUT (TIMEOUT)
   ) u_asm (
      .clk        (clk),
      .rst        (rst),
      .armed      (state_reg == ARMED),
      .rxvalid    (bus.rxvalid),
      .rxdata     (bus.rxdata),
      .word_valid (word_valid),
      .word       (word),
      .timeout    (timeout)
   );

   assign grant    = req_reg && bus.gnt;
   // acc_reg counts words taken into the pending slot; extra words are silently ignored.
   assign want     = word_valid && (acc_reg < 4'(NWORDS));
   assign accept   = want && (!pending_reg || grant);
   assign overflow = want && pending_reg && !grant;
   assign last     = grant && (wcount_reg == 4'(NWORDS - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg       <= IDLE;
         pending_reg     <= 1'b0;
         req_reg         <= 1'b0;
         addr_reg        <= '0;
         data_reg        <= '0;
         acc_reg         <= '0;
         wcount_reg      <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         err_timeout_reg <= 1'b0;
         err_ovf_reg     <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (state_reg == IDLE) begin
            if (start) begin
               state_reg       <= ARMED;
               busy_reg        <= 1'b1;
               err_timeout_reg <= 1'b0;
               err_ovf_reg     <= 1'b0;
               wcount_reg      <= '0;
               acc_reg         <= '0;
            end
         end else begin
            if (timeout)
               err_timeout_reg <= 1'b1;
            if (overflow)
               err_ovf_reg <= 1'b1;

            if (accept) begin
               pending_reg <= 1'b1;
               data_reg    <= word;
               addr_reg    <= word_addr(BASE_ADDR, acc_reg);
               acc_reg     <= acc_reg + 4'd1;
            end else if (grant) begin
               pending_reg <= 1'b0;
            end

            // A request always drops for one cycle after its grant, even if a
            // new word was taken on the grant cycle.
            if (grant) begin
               req_reg    <= 1'b0;
               wcount_reg <= wcount_reg + 4'd1;
            end else begin
               req_reg <= pending_reg || accept;
            end

            if (last) begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
            end
         end
      end
   end

   assign bus.req_o    = req_reg;
   assign bus.we       = req_reg;
   assign bus.w_addr   = addr_reg;
   assign bus.w_data   = data_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign err_timeout  = err_timeout_reg;
   assign err_ovf      = err_ovf_reg;
   assign wcount       = wcount_reg;

endmodule

// File: tb/tb_pc_rx_loader.sv
// Directed self-checking bench for pc_rx_loader.
module tb_pc_rx_loader;

   localparam int          TO   = 24864;
   localparam logic [31:0] BASE = 32'h10003F10;

   logic       clk;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic       err_timeout;
   logic       err_ovf;
   logic [3:0] wcount;

   int checks = 0;
   int passes = 0;
   int done_cnt = 0;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];

   pc_rx_loader_if bus();

   pc_rx_loader #(
      .BASE_ADDR (32'h10003F10),
      .NWORDS    (8),
      .TIMEOUT   (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .bus         (bus),
      .busy        (busy),
      .done        (done),
      .err_timeout (err_timeout),
      .err_ovf     (err_ovf),
      .wcount      (wcount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1 time unit after posedge, so at negedge they hold the
   // values the next posedge will sample.
   always @(negedge clk) begin
      if (rst === 1'b1 && bus.req_o === 1'b1 && bus.gnt === 1'b1) begin
         wa_q.push_back(bus.w_addr);
         wd_q.push_back(bus.w_data);
         $display("write addr=%h data=%h wcount=%0d", bus.w_addr, bus.w_data, wcount);
      end
      if (done === 1'b1) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rxvalid = 1'b1;
      bus.rxdata  = b;
      tick();
      bus.rxvalid = 1'b0;
      bus.rxdata  = 8'h00;
   endtask

   task automatic arm();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.req_o, bus.we, busy, done, err_timeout, err_ovf, wcount, bus.w_addr, bus.w_data} !== 74'd0)
         $display("FAIL reset_outputs: got req=%b we=%b busy=%b done=%b et=%b eo=%b wc=%0d addr=%h data=%h, want all 0",
                  bus.req_o, bus.we, busy, done, err_timeout, err_ovf, wcount, bus.w_addr, bus.w_data);
      else passes++;
      tick();
      rst = 1'b1;
      tick();
      arm();
      checks++;
      if (busy !== 1'b1) $display("FAIL arm_busy: got %b want 1", busy); else passes++;
   endtask

   task automatic test_basic();
      do_reset();
      bus.gnt = 1'b1;
      arm();
      for (int i = 0; i < 32; i++) begin
         send_byte(8'(i));
         repeat (99) tick();
      end
      checks++;
      if (wd_q.size() != 8) $display("FAIL basic_nwrites: got %0d want 8", wd_q.size()); else passes++;
      for (int k = 0; k < 8 && k < wd_q.size(); k++) begin
         logic [31:0] ea, ed;
         ea = BASE + 32'(4 * k);
         ed = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
         checks++;
         if (wa_q[k] !== ea || wd_q[k] !== ed)
            $display("FAIL basic_write%0d: got %h/%h want %h/%h", k, wa_q[k], wd_q[k], ea, ed);
         else passes++;
      end
      checks++;
      if (done_cnt != 1) $display("FAIL basic_done_cycles: got %0d want 1", done_cnt); else passes++;
      checks++;
      if ({busy, err_timeout, err_ovf, wcount} !== {3'b000, 4'd8})
         $display("FAIL basic_final: got busy=%b et=%b eo=%b wc=%0d want 0 0 0 8", busy, err_timeout, err_ovf, wcount);
      else passes++;
      bus.gnt = 1'b0;
   endtask

   task automatic test_handshake();
      logic [7:0] bytes [4];
      bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      do_reset();
      bus.gnt = 1'b0;
      arm();
      for (int i = 0; i < 3; i++) begin
         send_byte(bytes[i]);
         tick();
      end
      checks++;
      if (bus.req_o !== 1'b0) $display("FAIL hs_req_before: got %b want 0", bus.req_o); else passes++;
      send_byte(bytes[3]);
      for (int c = 1; c <= 6; c++) begin
         if (c == 6) bus.gnt = 1'b1;
         checks++;
         if ({bus.req_o, bus.we, bus.w_addr, bus.w_data} !== {2'b11, BASE, 32'hDEADBEEF})
            $display("FAIL hs_stable_c%0d: got req=%b we=%b %h/%h want 1 1 %h/deadbeef",
                     c, bus.req_o, bus.we, bus.w_addr, bus.w_data, BASE);
         else passes++;
         tick();
      end
      bus.gnt = 1'b0;
      checks++;
      if ({bus.req_o, bus.we, wcount} !== {2'b00, 4'd1})
         $display("FAIL hs_after_grant: got req=%b we=%b wc=%0d want 0 0 1", bus.req_o, bus.we, wcount);
      else passes++;
   endtask

   task automatic test_timeout();
      do_reset();
      bus.gnt = 1'b1;
      arm();
      send_byte(8'hAA);
      tick();
      send_byte(8'hBB);
      repeat (TO + 2) tick();
      checks++;
      if (err_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", err_timeout); else passes++;
      send_byte(8'h11); tick();
      send_byte(8'h22); tick();
      send_byte(8'h33); tick();
      send_byte(8'h44);
      repeat (4) tick();
      checks++;
      if (wd_q.size() < 1 || wa_q[0] !== BASE || wd_q[0] !== 32'h11223344)
         $display("FAIL to_first_write: got n=%0d %h/%h want %h/11223344", wd_q.size(),
                  wd_q.size() > 0 ? wa_q[0] : 32'h0, wd_q.size() > 0 ? wd_q[0] : 32'h0, BASE);
      else passes++;
      checks++;
      if ({err_timeout, err_ovf, wcount, busy} !== {2'b10, 4'd1, 1'b1})
         $display("FAIL to_state: got et=%b eo=%b wc=%0d busy=%b want 1 0 1 1", err_timeout, err_ovf, wcount, busy);
      else passes++;
      bus.gnt = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      bus.gnt = 1'b0;
      arm();
      for (int i = 1; i <= 8; i++) begin
         send_byte(8'(i));
         tick();
      end
      checks++;
      if ({err_ovf, wcount, bus.req_o, bus.w_data} !== {1'b1, 4'd0, 1'b1, 32'h01020304})
         $display("FAIL ovf_pending: got eo=%b wc=%0d req=%b data=%h want 1 0 1 01020304",
                  err_ovf, wcount, bus.req_o, bus.w_data);
      else passes++;
      bus.gnt = 1'b1;
      tick();
      bus.gnt = 1'b0;
      repeat (3) tick();
      checks++;
      if (wd_q.size() != 1 || wd_q[0] !== 32'h01020304 || wa_q[0] !== BASE)
         $display("FAIL ovf_written: got n=%0d first=%h want 1 write of 01020304", wd_q.size(),
                  wd_q.size() > 0 ? wd_q[0] : 32'h0);
      else passes++;
      checks++;
      if ({wcount, bus.req_o, err_ovf} !== {4'd1, 1'b0, 1'b1})
         $display("FAIL ovf_final: got wc=%0d req=%b eo=%b want 1 0 1", wcount, bus.req_o, err_ovf);
      else passes++;
   endtask

   task automatic test_reset_mid();
      int n0;
      do_reset();
      bus.gnt = 1'b1;
      arm();
      for (int i = 0; i < 12; i++) begin
         send_byte(8'(8'h80 + i));
         repeat (2) tick();
      end
      repeat (3) tick();
      checks++;
      if (wcount !== 4'd3) $display("FAIL mid_wcount: got %0d want 3", wcount); else passes++;
      send_byte(8'h8C); tick();
      send_byte(8'h8D);
      rst = 1'b0;
      tick();
      checks++;
      if ({bus.req_o, bus.we, busy, done, err_timeout, err_ovf, wcount, bus.w_addr, bus.w_data} !== 74'd0)
         $display("FAIL mid_reset_outputs: got req=%b busy=%b wc=%0d addr=%h data=%h want all 0",
                  bus.req_o, busy, wcount, bus.w_addr, bus.w_data);
      else passes++;
      rst = 1'b1;
      tick();
      n0 = wd_q.size();
      for (int i = 0; i < 4; i++) begin
         send_byte(8'(8'hC0 + i));
         tick();
      end
      repeat (3) tick();
      checks++;
      if (wd_q.size() != n0 || bus.req_o !== 1'b0)
         $display("FAIL mid_no_start: got %0d new writes req=%b want 0 0", wd_q.size() - n0, bus.req_o);
      else passes++;
      arm();
      for (int i = 0; i < 4; i++) begin
         send_byte(8'(8'h50 + i));
         tick();
      end
      repeat (3) tick();
      checks++;
      if (wd_q.size() != n0 + 1 || wa_q[n0] !== BASE || wd_q[n0] !== 32'h50515253)
         $display("FAIL mid_reload: got n=%0d %h/%h want %h/50515253", wd_q.size() - n0,
                  wd_q.size() > n0 ? wa_q[n0] : 32'h0, wd_q.size() > n0 ? wd_q[n0] : 32'h0, BASE);
      else passes++;
      bus.gnt = 1'b0;
   endtask

   task automatic test_gating();
      do_reset();
      bus.gnt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send_byte(8'(8'hF0 + i));
         tick();
      end
      checks++;
      if (wd_q.size() != 0 || busy !== 1'b0)
         $display("FAIL gate_idle: got %0d writes busy=%b want 0 0", wd_q.size(), busy);
      else passes++;
      arm();
      send_byte(8'h21); tick();
      send_byte(8'h22);
      arm();
      send_byte(8'h23); tick();
      send_byte(8'h24);
      repeat (3) tick();
      arm();
      for (int i = 0; i < 4; i++) begin
         send_byte(8'(8'h31 + i));
         if (i == 1) arm(); else tick();
      end
      repeat (3) tick();
      checks++;
      if (wd_q.size() != 2) $display("FAIL gate_nwrites: got %0d want 2", wd_q.size()); else passes++;
      if (wd_q.size() == 2) begin
         checks++;
         if (wa_q[0] !== BASE || wd_q[0] !== 32'h21222324)
            $display("FAIL gate_write0: got %h/%h want %h/21222324", wa_q[0], wd_q[0], BASE);
         else passes++;
         checks++;
         if (wa_q[1] !== BASE + 32'd4 || wd_q[1] !== 32'h31323334)
            $display("FAIL gate_write1: got %h/%h want %h/31323334", wa_q[1], wd_q[1], BASE + 32'd4);
         else passes++;
      end
      checks++;
      if ({wcount, busy} !== {4'd2, 1'b1})
         $display("FAIL gate_state: got wc=%0d busy=%b want 2 1", wcount, busy);
      else passes++;
      bus.gnt = 1'b0;
   endtask

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      bus.rxvalid = 1'b0;
      bus.rxdata  = 8'h00;
      bus.gnt     = 1'b0;
      tick();
      test_reset();
      test_basic();
      test_handshake();
      test_timeout();
      test_overflow();
      test_reset_mid();
      test_gating();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/pc_rx_loader.md
Name: pc_rx_loader

Overview:
- Receive-side counterpart of the RAM-to-PC byte dumper.
- Takes bytes arriving from the UART receiver and packs them into big-endian 32-bit words.
- Writes NWORDS words into data RAM starting at BASE_ADDR, then pulses done.
- Lets the host preload a RAM window, such as operands for a permutation run, through the same window the dumper reads back.

Parameters:
BASE_ADDR, 32'h10003F10, byte address of first word written
NWORDS, 8, number of 32-bit words per load (1..15)
TIMEOUT, 24864, idle clocks allowed between bytes of one word (≈2 byte times at current baud divider 12432)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
start  in  1  arm the loader (level or pulse; sampled in IDLE only)
rxvalid  in  1  one-cycle strobe, rxdata valid
rxdata  in  8  received byte
gnt  in  1  RAM accepts write this cycle (sampled while req_o=1)
req_o  out  1  RAM request
we  out  1  write enable, equal to req_o
w_addr  out  32  RAM byte address
w_data  out  32  RAM write data
busy  out  1  loader armed (ARMED state)
done  out  1  one-cycle pulse, load complete
err_timeout  out  1  sticky: partial word discarded on timeout
err_ovf  out  1  sticky: word dropped because previous write still pending
wcount  out  4  words written so far in current load

Behaviour:
- Reset (rst=0 at a clk edge): every output 0. State=IDLE. Byte index, word index, gap counter and pending flag cleared. Reset mid-load aborts without any further RAM access.
- States: IDLE, ARMED.
  - IDLE: rxvalid is ignored. start=1 moves to ARMED next cycle, sets busy=1, and clears err_timeout, err_ovf and wcount.
  - ARMED: start is ignored.
- Byte assembly (ARMED): each rxvalid shifts rxdata in big-endian order. First byte goes to [31:24], fourth byte to [7:0]. The byte index wraps 3→0.
- Word complete, with 4th byte at cycle T:
  - No write pending: pending set. At T+1, req_o=we=1, w_addr=BASE_ADDR+4*wcount, w_data=assembled word.
  - Write still pending: word dropped, err_ovf=1, wcount unchanged.
- Write handshake:
  - req_o, we, w_addr and w_data are held stable until gnt=1 is sampled with req_o=1.
  - On the cycle after grant: req_o=we=0, pending cleared, wcount+1.
  - Minimum spacing between writes is 2 cycles.
- Timeout: the gap counter clears on every rxvalid and counts only while ARMED and byte index≠0. When it reaches TIMEOUT: byte index=0, partial word discarded, err_timeout=1. The load continues.
- Completion: grant of word NWORDS-1 ends the load.
  - Next cycle: done=1 for exactly one cycle, state=IDLE, busy=0.
  - wcount holds NWORDS until the next start.
- Words assembled after NWORDS words have been accepted into pending are ignored, and no error is flagged.
- Simultaneous events:
  - rxvalid and gnt in the same cycle: both are processed. A word completing on the grant cycle counts as not pending (no overflow).
  - rxvalid on the same cycle timeout fires: rxvalid wins, the counter clears and no error is raised.
- Address arithmetic: 32-bit modulo, with no bounds check.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ARMED};
  - 2-bit byte-index type;
  - default BASE_ADDR;
  - baud divider constant 12432 (shared with the dumper), with TIMEOUT derived as 2×divider.
- One sub-module is natural: rx_word_assembler, containing the shift register, byte index and gap/timeout counter. Its outputs are word_valid (1-cycle) and word[31:0]. Top level keeps the FSM, pending register and RAM handshake.

Test Plan:
- Basic load: start, then 32 bytes 0x00..0x1F spaced 100 clk, gnt tied 1 → 8 writes.
  - First write: w_addr 0x10003F10, w_data 0x00010203.
  - Last write: 0x10003F2C, 0x1C1D1E1F.
  - Then one done pulse, busy=0, wcount=8, no errors.
- Latency/handshake: gnt held 0 for 5 cycles after req_o rises → addr/data stable all 6 cycles. req_o drops the cycle after gnt. Fourth byte to req_o is exactly 1 cycle.
- Timeout: send 0xAA,0xBB, wait TIMEOUT+2 clk, send 0x11,0x22,0x33,0x44 → err_timeout=1, and the first write carries 0x11223344 at 0x10003F10.
- Overflow: gnt held 0, send 8 bytes back-to-back (2 clk apart) → word 0x.. from the first 4 bytes is written after gnt, second word dropped, err_ovf=1, wcount=1.
- Reset mid-load: after 3 words written, pull rst low 1 cycle → all outputs 0. Bytes sent without start cause no req_o. A new start reloads from 0x10003F10.
- Gating: rxvalid in IDLE, and start pulses while ARMED → ignored. wcount and addresses are unaffected.
